// File: rtl/mult_booth_step.sv
// rtl/mult_booth_step.sv - radix-2 Booth step/sequencer feeding the 65-bit product register
// Optional overflow exception built when MULT_OVF_EN is defined.
module mult_booth_step (
    input  logic        clk,
    input  logic        ctrl_reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [64:0] data_readReg,
    output logic [64:0] data_writeReg,
    output logic        write_to,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        data_exception,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] m_q, m_d;
    logic [32:0] p_ext;
    logic [32:0] m_ext;
    logic [32:0] sum;

    // 33-bit add keeps the true sign so M = 0x80000000 negates correctly
    always_comb begin
        p_ext = {data_readReg[64], data_readReg[64:33]};
        m_ext = {m_q[31], m_q};
        case (data_readReg[1:0])
            2'b01:   sum = p_ext + m_ext;
            2'b10:   sum = p_ext - m_ext;
            default: sum = p_ext;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        m_d            = m_q;
        write_to       = 1'b0;
        data_writeReg  = data_readReg;
        data_resultRDY = 1'b0;
        case (state_q)
            RUN: begin
                write_to      = 1'b1;
                data_writeReg = {sum, data_readReg[32:1]};
                cnt_d         = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A start overrides whatever is in flight, including the DONE cycle
        if (ctrl_MULT && !ctrl_reset) begin
            write_to      = 1'b1;
            data_writeReg = {32'b0, data_operandB, 1'b0};
            m_d           = data_operandA;
            cnt_d         = 5'd0;
            state_d       = RUN;
        end
        if (ctrl_reset) begin
            write_to = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            m_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
        end
    end

    assign data_result = data_readReg[32:1];
    assign busy        = (state_q != IDLE);

`ifdef MULT_OVF_EN
    assign data_exception = data_resultRDY &&
                            (data_readReg[64:32] != {33{1'b0}}) &&
                            (data_readReg[64:32] != {33{1'b1}});
`else
    assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_step.sv
// tb/tb_mult_booth_step.sv - self-checking bench for mult_booth_step with a modelled mult_reg
module tb_mult_booth_step;

    logic        clk = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [64:0] data_readReg;
    logic [64:0] data_writeReg;
    logic        write_to;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    logic [64:0] mult_reg_q = '0;

    int errors = 0;
    int checks = 0;
    bit ovf_on;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            mult_reg_q <= '0;
        end else if (write_to) begin
            mult_reg_q <= data_writeReg;
        end
    end
    assign data_readReg = mult_reg_q;

    mult_booth_step dut (
        .clk            (clk),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_readReg   (data_readReg),
        .data_writeReg  (data_writeReg),
        .write_to       (write_to),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply operands at the current negedge; returns at the negedge after the sampling edge
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(negedge clk);
        ctrl_MULT     = 1'b0;
    endtask

    task automatic wait_rdy(input string name, output int n);
        bit busy_ok = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!data_resultRDY && !busy) busy_ok = 1'b0;
        end while (!data_resultRDY && n < 64);
        check({name, " latency"}, 64'(n), 64'd32);
        check({name, " busy during run"}, 64'(busy_ok), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input bit ovf);
        int n;
        start(a, b);
        wait_rdy(name, n);
        check({name, " result"}, 64'(data_result), 64'(lo));
        check({name, " product"}, 64'(mult_reg_q[64:1]), {hi, lo});
        check({name, " exception"}, 64'(data_exception), 64'(ovf & ovf_on));
        @(negedge clk);
        check({name, " rdy one cycle"}, 64'(data_resultRDY), 64'd0);
        check({name, " busy falls"}, 64'(busy), 64'd0);
        check({name, " result held"}, 64'(data_result), 64'(lo));
    endtask

    initial begin
        longint      prod;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;
        bit          seen;

`ifdef MULT_OVF_EN
        ovf_on = 1'b1;
`else
        ovf_on = 1'b0;
`endif
        vecs[0] = '{32'd3, 32'd5, 32'h0, 32'h0000000F, 1'b0};
        vecs[1] = '{32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1};
        vecs[5] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b1};
        vecs[6] = '{32'h0, 32'h12345678, 32'h0, 32'h0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0};

        repeat (2) @(negedge clk);
        ctrl_reset = 1'b0;
        check("reset rdy", 64'(data_resultRDY), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset write_to", 64'(write_to), 64'd0);
        check("reset exception", 64'(data_exception), 64'd0);
        check("reset result", 64'(data_result), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   vecs[i].ovf);
        end

        for (int i = 0; i < 20; i++) begin
            ra   = $urandom;
            rb   = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 200)) - 100);
            prod = longint'($signed(ra)) * longint'($signed(rb));
            run_op($sformatf("rand%0d", i), ra, rb, prod[63:32], prod[31:0],
                   (prod > 64'sd2147483647) || (prod < -64'sd2147483648));
        end

        // Restart mid-run: first operation never reports
        start(32'd3, 32'd5);
        seen = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (data_resultRDY) seen = 1'b1;
        end
        start(32'd2, 32'hFFFFFFFC);
        check("abort no rdy", 64'(seen), 64'd0);
        wait_rdy("restart", n);
        check("restart result", 64'(data_result), 64'hFFFFFFF8);
        @(negedge clk);

        // New start accepted in the DONE cycle
        start(32'd7, 32'd11);
        wait_rdy("done-restart first", n);
        check("done-restart first result", 64'(data_result), 64'd77);
        start(32'hFFFFFFFD, 32'd4);
        check("done-restart busy", 64'(busy), 64'd1);
        wait_rdy("done-restart second", n);
        check("done-restart second result", 64'(data_result), 64'hFFFFFFF4);
        @(negedge clk);

        // Reset mid-run
        start(32'd123, 32'd456);
        repeat (19) @(negedge clk);
        ctrl_reset = 1'b1;
        @(negedge clk);
        ctrl_reset = 1'b0;
        check("midreset rdy", 64'(data_resultRDY), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset write_to", 64'(write_to), 64'd0);
        check("midreset exception", 64'(data_exception), 64'd0);
        check("midreset result", 64'(data_result), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (data_resultRDY || busy) seen = 1'b1;
        end
        check("midreset quiet", 64'(seen), 64'd0);
        run_op("after reset 9x9", 32'd9, 32'd9, 32'h0, 32'd81, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
